alu_share_arbiter: RTL and testbench

//  Shares one combinational ALU instance between two requesters, e.g. the main

---
 rtl/alu_share_arbiter.sv | 219 +++++++++++++++++++++
 tb/tb_alu_share_arbiter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// -----------------------------------------------------------------------------
// alu_share_arbiter
//   Shares one external combinational ALU between two requesters (port 0: main
//   integer path, port 1: address/branch-target path). Requests use valid/ready
//   with round-robin arbitration. The ALU result is captured into a response
//   register that holds until the consumer accepts it. Back-to-back issue is
//   allowed while the response is being accepted, giving one op per cycle.
//
//   Optional feature macro: ALU_ARB_ILLEGAL_CHK_EN
//     Adds resp_err. An illegal granted control code is still handshaken, but
//     its response is forced to data=0, zero=0, err=1.
//
// Ports
//   clk, rst            clock and synchronous active-high reset
//   reqN_valid/ready    request handshake for requester N (N = 0, 1)
//   reqN_ctrl/rs1/rs2/imm  request payload for requester N
//   alu_ctrl/rs1/rs2/imm   drive to the shared ALU (all-zero when idle)
//   alu_out, alu_zero   result from the shared ALU
//   resp_valid/ready    response handshake
//   resp_id             requester that owns the response
//   resp_data/zero      captured ALU result and zero flag
//   resp_err            (macro only) illegal control code flag
// -----------------------------------------------------------------------------
module alu_share_arbiter #(
  parameter int REG_WIDTH     = 64,
  parameter int ALU_CTRL_BITS = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req0_valid,
  output logic                     req0_ready,
  input  logic [ALU_CTRL_BITS-1:0] req0_ctrl,
  input  logic [REG_WIDTH-1:0]     req0_rs1,
  input  logic [REG_WIDTH-1:0]     req0_rs2,
  input  logic [REG_WIDTH-1:0]     req0_imm,
  input  logic                     req1_valid,
  output logic                     req1_ready,
  input  logic [ALU_CTRL_BITS-1:0] req1_ctrl,
  input  logic [REG_WIDTH-1:0]     req1_rs1,
  input  logic [REG_WIDTH-1:0]     req1_rs2,
  input  logic [REG_WIDTH-1:0]     req1_imm,
  output logic [ALU_CTRL_BITS-1:0] alu_ctrl,
  output logic [REG_WIDTH-1:0]     alu_rs1,
  output logic [REG_WIDTH-1:0]     alu_rs2,
  output logic [REG_WIDTH-1:0]     alu_imm,
  input  logic [REG_WIDTH-1:0]     alu_out,
  input  logic                     alu_zero,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic                     resp_id,
  output logic [REG_WIDTH-1:0]     resp_data,
`ifdef ALU_ARB_ILLEGAL_CHK_EN
  output logic                     resp_zero,
  output logic                     resp_err
`else
  output logic                     resp_zero
`endif
);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic                 r_last_grant;
  logic                 r_resp_id;
  logic [REG_WIDTH-1:0] r_resp_data;
  logic                 r_resp_zero;

  // Requests gathered into arrays so the per-port logic is written once.
  logic                     w_req_valid [2];
  logic [ALU_CTRL_BITS-1:0] w_req_ctrl  [2];
  logic [REG_WIDTH-1:0]     w_req_rs1   [2];
  logic [REG_WIDTH-1:0]     w_req_rs2   [2];
  logic [REG_WIDTH-1:0]     w_req_imm   [2];
  logic                     w_ready     [2];

  logic w_can_issue;
  logic w_gnt_valid;
  logic w_gnt_id;
  logic w_issue;

  assign w_req_valid[0] = req0_valid;
  assign w_req_ctrl[0]  = req0_ctrl;
  assign w_req_rs1[0]   = req0_rs1;
  assign w_req_rs2[0]   = req0_rs2;
  assign w_req_imm[0]   = req0_imm;
  assign w_req_valid[1] = req1_valid;
  assign w_req_ctrl[1]  = req1_ctrl;
  assign w_req_rs1[1]   = req1_rs1;
  assign w_req_rs2[1]   = req1_rs2;
  assign w_req_imm[1]   = req1_imm;

  // A slot is free when empty, or when the held response leaves this cycle.
  assign w_can_issue = (r_state == IDLE) | resp_ready;

  // Round-robin: on a tie the port that did not win last time is granted.
  always_comb begin
    w_gnt_valid = 1'b0;
    w_gnt_id    = 1'b0;
    case ({w_req_valid[1], w_req_valid[0]})
      2'b01: begin
        w_gnt_valid = 1'b1;
        w_gnt_id    = 1'b0;
      end
      2'b10: begin
        w_gnt_valid = 1'b1;
        w_gnt_id    = 1'b1;
      end
      2'b11: begin
        w_gnt_valid = 1'b1;
        w_gnt_id    = ~r_last_grant;
      end
      default: begin
        w_gnt_valid = 1'b0;
        w_gnt_id    = 1'b0;
      end
    endcase
  end

  // Reset gates the handshake so nothing is accepted while rst is high.
  assign w_issue = w_can_issue & w_gnt_valid & ~rst;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_ready
      assign w_ready[gi] = w_issue & (w_gnt_id == gi[0]);
    end
  endgenerate

  assign req0_ready = w_ready[0];
  assign req1_ready = w_ready[1];

  // Idle ALU inputs are driven to zero so no X reaches the ALU.
  always_comb begin
    alu_ctrl = '0;
    alu_rs1  = '0;
    alu_rs2  = '0;
    alu_imm  = '0;
    if (w_gnt_valid) begin
      alu_ctrl = w_req_ctrl[w_gnt_id];
      alu_rs1  = w_req_rs1[w_gnt_id];
      alu_rs2  = w_req_rs2[w_gnt_id];
      alu_imm  = w_req_imm[w_gnt_id];
    end
  end

  // FSM: state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM: next state.
  always_comb begin
    w_state_next = r_state;
    if (w_issue) begin
      w_state_next = HOLD;
    end else if ((r_state == HOLD) && resp_ready) begin
      w_state_next = IDLE;
    end
  end

`ifdef ALU_ARB_ILLEGAL_CHK_EN
  logic r_resp_err;
  logic w_ctrl_legal;
  logic [31:0] w_ctrl_ext;

  // Legal codes: 0-9, 16-24, 30, 31.
  assign w_ctrl_ext   = 32'(alu_ctrl);
  assign w_ctrl_legal = (w_ctrl_ext <= 32'd9) ||
                        ((w_ctrl_ext >= 32'd16) && (w_ctrl_ext <= 32'd24)) ||
                        (w_ctrl_ext == 32'd30) || (w_ctrl_ext == 32'd31);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_grant <= 1'b1;
      r_resp_id    <= 1'b0;
      r_resp_data  <= '0;
      r_resp_zero  <= 1'b0;
      r_resp_err   <= 1'b0;
    end else if (w_issue) begin
      r_last_grant <= w_gnt_id;
      r_resp_id    <= w_gnt_id;
      r_resp_data  <= w_ctrl_legal ? alu_out : '0;
      r_resp_zero  <= w_ctrl_legal ? alu_zero : 1'b0;
      r_resp_err   <= ~w_ctrl_legal;
    end
  end

  assign resp_err = r_resp_err;
`else
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_grant <= 1'b1;
      r_resp_id    <= 1'b0;
      r_resp_data  <= '0;
      r_resp_zero  <= 1'b0;
    end else if (w_issue) begin
      r_last_grant <= w_gnt_id;
      r_resp_id    <= w_gnt_id;
      r_resp_data  <= alu_out;
      r_resp_zero  <= alu_zero;
    end
  end
`endif

  assign resp_valid = (r_state == HOLD);
  assign resp_id    = r_resp_id;
  assign resp_data  = r_resp_data;
  assign resp_zero  = r_resp_zero;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_share_arbiter
//   Directed bench for alu_share_arbiter with a small behavioural ALU:
//   ctrl 0 = add, 1 = sub, 31 = pass imm, anything else = rs1 ^ rs2;
//   zero flag = (rs1 == rs2). Inputs change 1 time unit after the rising
//   edge; outputs are checked 2 time units later, well away from the edge.
// -----------------------------------------------------------------------------
module tb_alu_share_arbiter;

  localparam int W  = 64;
  localparam int CB = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0_valid, req1_valid;
  logic          req0_ready, req1_ready;
  logic [CB-1:0] req0_ctrl, req1_ctrl;
  logic [W-1:0]  req0_rs1, req0_rs2, req0_imm;
  logic [W-1:0]  req1_rs1, req1_rs2, req1_imm;
  logic [CB-1:0] alu_ctrl;
  logic [W-1:0]  alu_rs1, alu_rs2, alu_imm;
  logic [W-1:0]  alu_out;
  logic          alu_zero;
  logic          resp_valid, resp_ready, resp_id, resp_zero;
  logic [W-1:0]  resp_data;
`ifdef ALU_ARB_ILLEGAL_CHK_EN
  logic          resp_err;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // Behavioural ALU model.
  always_comb begin
    case (alu_ctrl)
      5'd0:    alu_out = alu_rs1 + alu_rs2;
      5'd1:    alu_out = alu_rs1 - alu_rs2;
      5'd31:   alu_out = alu_imm;
      default: alu_out = alu_rs1 ^ alu_rs2;
    endcase
    alu_zero = (alu_rs1 == alu_rs2);
  end

  alu_share_arbiter #(.REG_WIDTH(W), .ALU_CTRL_BITS(CB)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_ctrl  (req0_ctrl),
    .req0_rs1   (req0_rs1),
    .req0_rs2   (req0_rs2),
    .req0_imm   (req0_imm),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_ctrl  (req1_ctrl),
    .req1_rs1   (req1_rs1),
    .req1_rs2   (req1_rs2),
    .req1_imm   (req1_imm),
    .alu_ctrl   (alu_ctrl),
    .alu_rs1    (alu_rs1),
    .alu_rs2    (alu_rs2),
    .alu_imm    (alu_imm),
    .alu_out    (alu_out),
    .alu_zero   (alu_zero),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_data  (resp_data),
`ifdef ALU_ARB_ILLEGAL_CHK_EN
    .resp_zero  (resp_zero),
    .resp_err   (resp_err)
`else
    .resp_zero  (resp_zero)
`endif
  );

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge (drive point).
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Let combinational paths settle before checking.
  task automatic settle();
    #2;
  endtask

  task automatic chk_resp(input string tag, input logic v, input logic id,
                          input logic [W-1:0] d, input logic z);
    chk({tag, ".resp_valid"}, W'(resp_valid), W'(v));
    chk({tag, ".resp_id"},    W'(resp_id),    W'(id));
    chk({tag, ".resp_data"},  resp_data,      d);
    chk({tag, ".resp_zero"},  W'(resp_zero),  W'(z));
    $display("step %s: valid=%0b id=%0b data=0x%0h zero=%0b r0=%0b r1=%0b",
             tag, resp_valid, resp_id, resp_data, resp_zero, req0_ready, req1_ready);
  endtask

  task automatic chk_rdy(input string tag, input logic r0, input logic r1);
    chk({tag, ".req0_ready"}, W'(req0_ready), W'(r0));
    chk({tag, ".req1_ready"}, W'(req1_ready), W'(r1));
  endtask

  initial begin
    rst = 1'b1;
    req0_valid = 1'b1; req0_ctrl = 5'd0; req0_rs1 = 64'd1; req0_rs2 = 64'd2; req0_imm = 64'd0;
    req1_valid = 1'b1; req1_ctrl = 5'd0; req1_rs1 = 64'd3; req1_rs2 = 64'd4; req1_imm = 64'd0;
    resp_ready = 1'b1;

    // 1. Reset for two cycles with both requesters valid.
    #1;
    settle();
    chk_rdy("rst_c0", 1'b0, 1'b0);
    tick();
    settle();
    chk_rdy("rst_c1", 1'b0, 1'b0);
    chk_resp("rst_c1", 1'b0, 1'b0, 64'd0, 1'b0);
    tick();
    rst = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    settle();
    chk_resp("rst_done", 1'b0, 1'b0, 64'd0, 1'b0);
    chk("idle_alu_ctrl", W'(alu_ctrl), 64'd0);
    chk("idle_alu_rs1", alu_rs1, 64'd0);

    // 2. Single op from requester 0: 5 + 7 = 12.
    req0_valid = 1'b1; req0_ctrl = 5'd0; req0_rs1 = 64'd5; req0_rs2 = 64'd7;
    settle();
    chk_rdy("single_T", 1'b1, 1'b0);
    chk("single_alu_rs1", alu_rs1, 64'd5);
    chk("single_alu_rs2", alu_rs2, 64'd7);
    tick();
    req0_valid = 1'b0;
    settle();
    chk_resp("single_T1", 1'b1, 1'b0, 64'd12, 1'b0);
    tick();
    settle();
    chk_resp("single_drain", 1'b0, 1'b0, 64'd12, 1'b0);

    // Reset again so the first tie goes to requester 0.
    rst = 1'b1;
    tick();
    rst = 1'b0;

    // 3. Round-robin: req0 ctrl=1 9-9 (zero), req1 ctrl=0 3+4=7.
    req0_valid = 1'b1; req0_ctrl = 5'd1; req0_rs1 = 64'd9; req0_rs2 = 64'd9;
    req1_valid = 1'b1; req1_ctrl = 5'd0; req1_rs1 = 64'd3; req1_rs2 = 64'd4;
    resp_ready = 1'b1;
    settle();
    chk_rdy("rr_c0", 1'b1, 1'b0);
    tick();
    settle();
    chk_resp("rr_c1", 1'b1, 1'b0, 64'd0, 1'b1);
    chk_rdy("rr_c1", 1'b0, 1'b1);
    tick();
    settle();
    chk_resp("rr_c2", 1'b1, 1'b1, 64'd7, 1'b0);
    chk_rdy("rr_c2", 1'b1, 1'b0);
    tick();

    // 4. Backpressure: hold response id0 for three cycles while req1 waits.
    req0_valid = 1'b0;
    req1_rs1 = 64'h100; req1_rs2 = 64'h23;
    resp_ready = 1'b0;
    settle();
    chk_resp("bp_c0", 1'b1, 1'b0, 64'd0, 1'b1);
    chk_rdy("bp_c0", 1'b0, 1'b0);
    tick();
    settle();
    chk_resp("bp_c1", 1'b1, 1'b0, 64'd0, 1'b1);
    chk_rdy("bp_c1", 1'b0, 1'b0);
    tick();
    settle();
    chk_resp("bp_c2", 1'b1, 1'b0, 64'd0, 1'b1);
    chk_rdy("bp_c2", 1'b0, 1'b0);
    tick();
    resp_ready = 1'b1;
    settle();
    chk_rdy("bp_release", 1'b0, 1'b1);
    chk_resp("bp_release", 1'b1, 1'b0, 64'd0, 1'b1);
    tick();
    req1_valid = 1'b0;
    resp_ready = 1'b0;
    settle();
    chk_resp("bp_after", 1'b1, 1'b1, 64'h123, 1'b0);

    // 5. Reset while holding a response that has not been accepted.
    rst = 1'b1;
    settle();
    chk_rdy("mid_rst", 1'b0, 1'b0);
    tick();
    rst = 1'b0;
    settle();
    chk_resp("mid_rst_c1", 1'b0, 1'b0, 64'd0, 1'b0);
    tick();
    resp_ready = 1'b1;
    settle();
    chk_resp("mid_rst_c2", 1'b0, 1'b0, 64'd0, 1'b0);

    // 6. Illegal code check (feature build) and imm pass-through (both builds).
`ifdef ALU_ARB_ILLEGAL_CHK_EN
    req0_valid = 1'b1; req0_ctrl = 5'b01010; req0_rs1 = 64'd1; req0_rs2 = 64'd2;
    settle();
    chk_rdy("ill_T", 1'b1, 1'b0);
    tick();
    req0_valid = 1'b0;
    settle();
    chk_resp("ill_T1", 1'b1, 1'b0, 64'd0, 1'b0);
    chk("ill_resp_err", W'(resp_err), 64'd1);
    tick();
`endif
    req0_valid = 1'b1; req0_ctrl = 5'b11111; req0_rs1 = 64'd1; req0_rs2 = 64'd2;
    req0_imm = 64'h1000;
    settle();
    chk_rdy("imm_T", 1'b1, 1'b0);
    tick();
    req0_valid = 1'b0;
    settle();
    chk_resp("imm_T1", 1'b1, 1'b0, 64'h1000, 1'b0);
`ifdef ALU_ARB_ILLEGAL_CHK_EN
    chk("imm_resp_err", W'(resp_err), 64'd0);
`endif
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
